kalman_gain_2x2: RTL and testbench

Sequential 2x2 fixed-point matrix multiplier that forms the Kalman gain K = (P·Hᵀ)·S⁻¹. It sits directly downstream of the 2x2 matrix inversion stage: it consumes the inverted innovation covariance S⁻¹ once the inverter's end pulse fires, together with P·Hᵀ from the covariance stage. It produces K for the state-update stage. One shared signed multiplier/accumulator is time-multiplexed over eight products.

---
 rtl/kalman_gain_2x2.sv | 148 ++++++++++++++
 tb/tb_kalman_gain_2x2.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/kalman_gain_2x2.sv
// kalman_gain_2x2: forms K = (P*H^T) * S^-1 for 2x2 fixed-point matrices using
// one shared signed multiply/accumulate, eight products per run.
// Optional build macro KGAIN_SATURATE_EN: clamp each element to the WIDTH range
// and expose a sticky sat_flag; otherwise elements wrap to their low WIDTH bits.
module kalman_gain_2x2 #(
    parameter int WIDTH = 16,
    parameter int FRAC  = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        clk_en,
    input  logic                        startMul,
    input  logic [1:0][1:0][WIDTH-1:0]  A,
    input  logic [1:0][1:0][WIDTH-1:0]  B,
    output logic [1:0][1:0][WIDTH-1:0]  K,
    output logic                        busy,
`ifdef KGAIN_SATURATE_EN
    output logic                        endMul,
    output logic                        sat_flag
`else
    output logic                        endMul
`endif
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam int AW = 2 * WIDTH + 1;

    logic [1:0]                 state_q, state_d;
    logic [2:0]                 cnt_q, cnt_d;
    logic signed [AW-1:0]       acc_q, acc_d;
    logic [1:0][1:0][WIDTH-1:0] a_q, a_d, b_q, b_d, kb_q, kb_d, k_q, k_d;

    // Product operand selection: cnt walks K00, K01, K10, K11 with two terms each.
    logic ii, jj, kk;
    assign ii = cnt_q[2];
    assign jj = cnt_q[1];
    assign kk = cnt_q[0];

    logic signed [2*WIDTH-1:0] op_a, op_b, prod;
    logic signed [AW-1:0]      prod_x, sum;
    logic [WIDTH-1:0]          res;

    assign op_a   = $signed({{WIDTH{a_q[ii][kk][WIDTH-1]}}, a_q[ii][kk]});
    assign op_b   = $signed({{WIDTH{b_q[kk][jj][WIDTH-1]}}, b_q[kk][jj]});
    assign prod   = op_a * op_b;
    assign prod_x = $signed({prod[2*WIDTH-1], prod});
    assign sum    = acc_q + prod_x;

`ifdef KGAIN_SATURATE_EN
    localparam logic signed [AW-1:0] SMAX = {{(WIDTH+2){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic signed [AW-1:0] SMIN = {{(WIDTH+2){1'b1}}, {(WIDTH-1){1'b0}}};
    logic signed [AW-1:0] shifted;
    logic                 clamp;
    logic                 sat_q, sat_d;
    assign shifted = sum >>> FRAC;
    assign clamp   = (shifted > SMAX) || (shifted < SMIN);
    assign res     = (shifted > SMAX) ? SMAX[WIDTH-1:0] :
                     (shifted < SMIN) ? SMIN[WIDTH-1:0] : shifted[WIDTH-1:0];
    assign sat_flag = sat_q;
`else
    // Wrap-around: keep only the low WIDTH bits of the rescaled sum.
    assign res = WIDTH'(sum >>> FRAC);
`endif

    // Next-state: sequencing, operand capture, accumulation and result buffering.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        a_d     = a_q;
        b_d     = b_q;
        kb_d    = kb_q;
        k_d     = k_q;
`ifdef KGAIN_SATURATE_EN
        sat_d   = sat_q;
`endif
        if (clk_en) begin
            case (state_q)
                IDLE: begin
                    if (startMul) begin
                        state_d = RUN;
                        cnt_d   = 3'd0;
                        acc_d   = '0;
                        a_d     = A;
                        b_d     = B;
`ifdef KGAIN_SATURATE_EN
                        sat_d   = 1'b0;
`endif
                    end
                end
                RUN: begin
                    cnt_d = cnt_q + 3'd1;
                    if (!cnt_q[0]) begin
                        acc_d = prod_x;
                    end else begin
                        kb_d[ii][jj] = res;
`ifdef KGAIN_SATURATE_EN
                        sat_d = sat_q | clamp;
`endif
                    end
                    // Last product: publish the whole matrix at once, K11 bypassing Kb.
                    if (cnt_q == 3'd7) begin
                        state_d   = DONE;
                        k_d       = kb_q;
                        k_d[1][1] = res;
                    end
                end
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            kb_q    <= '0;
            k_q     <= '0;
`ifdef KGAIN_SATURATE_EN
            sat_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            a_q     <= a_d;
            b_q     <= b_d;
            kb_q    <= kb_d;
            k_q     <= k_d;
`ifdef KGAIN_SATURATE_EN
            sat_q   <= sat_d;
`endif
        end
    end

    assign K      = k_q;
    assign busy   = (state_q != IDLE);
    assign endMul = (state_q == DONE);

endmodule

// File: tb/tb_kalman_gain_2x2.sv
// Bench for kalman_gain_2x2: directed table, random runs against a matrix
// model, clock-enable stretching and asynchronous abort sequences.
module tb_kalman_gain_2x2;

    typedef logic [1:0][1:0][15:0] mat_t;
    typedef struct {
        mat_t  a;
        mat_t  b;
        mat_t  k;
        string nm;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic clk_en = 1'b0;
    logic startMul = 1'b0;
    mat_t A_i = '0, B_i = '0;
    mat_t K_o;
    logic busy, endMul;
`ifdef KGAIN_SATURATE_EN
    logic sat_flag;
`endif

    int   n_vec = 0;
    int   n_err = 0;
    mat_t exp_k = '0;
    bit   exp_sat = 1'b0;

    kalman_gain_2x2 #(.WIDTH(16), .FRAC(8)) dut (
        .clk(clk), .rst(rst), .clk_en(clk_en), .startMul(startMul),
        .A(A_i), .B(B_i), .K(K_o), .busy(busy),
`ifdef KGAIN_SATURATE_EN
        .endMul(endMul), .sat_flag(sat_flag)
`else
        .endMul(endMul)
`endif
    );

    always #5 clk = ~clk;

    function automatic mat_t mk(input int m00, input int m01, input int m10, input int m11);
        mat_t m;
        m[0][0] = m00[15:0]; m[0][1] = m01[15:0];
        m[1][0] = m10[15:0]; m[1][1] = m11[15:0];
        return m;
    endfunction

    // Reference: plain matrix product, rescale by 2^-8 toward -inf, then wrap or clamp.
    function automatic void model(input mat_t a, input mat_t b, output mat_t k, output bit sat);
        sat = 1'b0;
        for (int i = 0; i < 2; i++) begin
            for (int j = 0; j < 2; j++) begin
                longint a0 = $signed(a[i][0]);
                longint a1 = $signed(a[i][1]);
                longint b0 = $signed(b[0][j]);
                longint b1 = $signed(b[1][j]);
                longint s  = (a0 * b0 + a1 * b1) >>> 8;
`ifdef KGAIN_SATURATE_EN
                if (s > 32767) begin k[i][j] = 16'h7FFF; sat = 1'b1; end
                else if (s < -32768) begin k[i][j] = 16'h8000; sat = 1'b1; end
                else k[i][j] = s[15:0];
`else
                k[i][j] = s[15:0];
`endif
            end
        end
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, expv);
        end
    endtask

    task automatic chk_ctl(input string nm, input bit eb, input bit ee);
        chk({nm, ".busy"}, 64'(busy), 64'(eb));
        chk({nm, ".endMul"}, 64'(endMul), 64'(ee));
    endtask

    // One full run from accept (E0) to return to IDLE (E9); called at a negedge.
    task automatic do_run(input mat_t a, input mat_t b, input mat_t ek, input bit es, input string nm);
        int pulse;
        pulse    = int'($urandom_range(1, 8));
        A_i      = a;
        B_i      = b;
        startMul = 1'b1;
        clk_en   = 1'b1;
        for (int e = 0; e <= 9; e++) begin
            @(posedge clk);
            @(negedge clk);
            startMul = (e + 1 == pulse);
            A_i = {$urandom, $urandom};
            B_i = {$urandom, $urandom};
            if (e < 8) begin
                chk_ctl($sformatf("%s.E%0d", nm, e), 1'b1, 1'b0);
                chk($sformatf("%s.Khold.E%0d", nm, e), K_o, exp_k);
`ifdef KGAIN_SATURATE_EN
                if (e == 0) chk({nm, ".satclr"}, 64'(sat_flag), 64'(0));
`endif
            end else begin
                if (e == 8) exp_k = ek;
                chk_ctl($sformatf("%s.E%0d", nm, e), e == 8, e == 8);
                chk($sformatf("%s.K.E%0d", nm, e), K_o, exp_k);
            end
        end
        exp_sat = es;
`ifdef KGAIN_SATURATE_EN
        chk({nm, ".sat"}, 64'(sat_flag), 64'(exp_sat));
`endif
    endtask

    initial begin
        vec_t tbl[4];
        mat_t mk_k;
        bit   ms;
        int   en_cnt;

        tbl[0] = '{mk(256, 0, 0, 256), mk(256, 512, -256, 768), mk(256, 512, -256, 768), "identity"};
        tbl[1] = '{mk(512, 256, 0, 256), mk(256, 256, 256, 0), mk(768, 512, 256, 0), "general"};
        tbl[2] = '{mk(-256, 0, 0, -256), mk(1, 0, 0, 1), mk(16'hFFFF, 0, 0, 16'hFFFF), "negtrunc"};
`ifdef KGAIN_SATURATE_EN
        tbl[3] = '{mk(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF), mk(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF),
                   mk(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF), "overflow"};
`else
        tbl[3] = '{mk(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF), mk(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF),
                   mk(16'hFE00, 16'hFE00, 16'hFE00, 16'hFE00), "overflow"};
`endif

        // Reset state.
        repeat (2) @(negedge clk);
        chk("reset.K", K_o, 64'(0));
        chk_ctl("reset", 1'b0, 1'b0);
        rst = 1'b0;
        @(negedge clk);

        // Directed vectors; general product runs first so K is seen leaving 0.
        do_run(tbl[1].a, tbl[1].b, tbl[1].k, 1'b0, tbl[1].nm);
        do_run(tbl[0].a, tbl[0].b, tbl[0].k, 1'b0, tbl[0].nm);
        do_run(tbl[2].a, tbl[2].b, tbl[2].k, 1'b0, tbl[2].nm);
`ifdef KGAIN_SATURATE_EN
        do_run(tbl[3].a, tbl[3].b, tbl[3].k, 1'b1, tbl[3].nm);
`else
        do_run(tbl[3].a, tbl[3].b, tbl[3].k, 1'b0, tbl[3].nm);
`endif

        // Random back-to-back runs against the model.
        for (int r = 0; r < 24; r++) begin
            mat_t ra, rb;
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            if (r % 3 == 0) begin
                for (int i = 0; i < 2; i++)
                    for (int j = 0; j < 2; j++) begin
                        ra[i][j] = 16'($signed(int'($urandom_range(0, 2048)) - 1024));
                        rb[i][j] = 16'($signed(int'($urandom_range(0, 2048)) - 1024));
                    end
            end
            model(ra, rb, mk_k, ms);
            do_run(ra, rb, mk_k, ms, $sformatf("rand%0d", r));
        end

        // clk_en toggling 1,0,1,0 from E0: completion after the 9th enabled edge.
        A_i = mk(512, 256, 0, 256);
        B_i = mk(256, 256, 256, 0);
        startMul = 1'b1;
        clk_en   = 1'b1;
        en_cnt   = 0;
        for (int c = 0; c < 40 && en_cnt < 9; c++) begin
            bit was_en;
            was_en = clk_en;
            @(posedge clk);
            @(negedge clk);
            if (was_en) en_cnt++;
            startMul = (c == 5);
            A_i = {$urandom, $urandom};
            B_i = {$urandom, $urandom};
            clk_en = ((c + 1) % 2 == 0);
            chk_ctl($sformatf("cken.c%0d", c), 1'b1, en_cnt == 9);
            if (en_cnt == 9) chk("cken.clocks", 64'(c + 1), 64'(17));
        end
        chk("cken.count", 64'(en_cnt), 64'(9));
        exp_k = mk(768, 512, 256, 0);
        chk("cken.K", K_o, exp_k);
        clk_en = 1'b0;
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
            chk_ctl("cken.hold", 1'b1, 1'b1);
        end
        clk_en = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk_ctl("cken.exit", 1'b0, 1'b0);
        chk("cken.Kafter", K_o, exp_k);

        // Asynchronous abort after E4, then a clean full run.
        A_i = mk(256, 0, 0, 256);
        B_i = mk(100, 200, 300, 400);
        startMul = 1'b1;
        for (int e = 0; e <= 4; e++) begin
            @(posedge clk);
            @(negedge clk);
            startMul = 1'b0;
        end
        rst = 1'b1;
        #1;
        chk("abort.K", K_o, 64'(0));
        chk_ctl("abort", 1'b0, 1'b0);
        @(posedge clk);
        @(negedge clk);
        chk_ctl("abort.held", 1'b0, 1'b0);
        rst = 1'b0;
        exp_k = '0;
        do_run(mk(256, 0, 0, 256), mk(100, 200, 300, 400), mk(100, 200, 300, 400), 1'b0, "postabort");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
